// File: rtl/modul_lab7.sv
// Registered N-to-1 single-bit multiplexer with enable and valid flag.
// It also provides a registered one-hot decode of the captured select.
module modul_lab7 #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned N_IN  = 4,
    parameter logic        RST_Y = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [SEL_W-1:0]  a,
    input  logic [N_IN-1:0]   d,
    output logic              y,
    output logic              y_valid,
    output logic [N_IN-1:0]   sel_onehot
);

    logic [N_IN-1:0] dec;
    logic            sel_legal;
    logic            mux_y;

    // An out-of-range select decodes to all zeros.
    // That single fact clears y, y_valid and sel_onehot together.
    for (genvar i = 0; i < N_IN; i++) begin : g_dec
        assign dec[i] = (a == SEL_W'(i));
    end

    always_comb begin
        sel_legal = |dec;
        mux_y     = |(dec & d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y          <= RST_Y;
            y_valid    <= 1'b0;
            sel_onehot <= '0;
        end else if (en) begin
            y          <= mux_y;
            y_valid    <= sel_legal;
            sel_onehot <= dec;
        end
    end

endmodule

// File: tb/tb_modul_lab7.sv
// Self-checking bench for modul_lab7: a default 4:1 instance and a 3-input
// instance, compared every cycle against an arithmetic reference model.
module tb_modul_lab7;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] a, a3;
    logic [3:0] d;
    logic [2:0] d3;
    logic       y, y_valid, y3, y3_valid;
    logic [3:0] sel_onehot;
    logic [2:0] sel3_onehot;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Reference-model expectations for both instances.
    logic       m_y, m_v, m3_y, m3_v;
    logic [3:0] m_oh;
    logic [2:0] m3_oh;

    always #5 clk = ~clk;

    modul_lab7 #(.SEL_W(2), .N_IN(4), .RST_Y(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .d(d),
        .y(y), .y_valid(y_valid), .sel_onehot(sel_onehot)
    );

    modul_lab7 #(.SEL_W(2), .N_IN(3), .RST_Y(1'b0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .a(a3), .d(d3),
        .y(y3), .y_valid(y3_valid), .sel_onehot(sel3_onehot)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model works from the mux rules: a legal index selects bit d >> a
    // and sets bit a of the one-hot view; an illegal index clears everything.
    always @(posedge clk) begin
        if (rst) begin
            m_y = 1'b0;  m_v = 1'b0;  m_oh = '0;
            m3_y = 1'b0; m3_v = 1'b0; m3_oh = '0;
        end else if (en) begin
            m_y  = ((d >> a) & 4'd1) != 0;
            m_v  = 1'b1;
            m_oh = 4'(1 << a);
            if (a3 < 3) begin
                m3_y = ((d3 >> a3) & 3'd1) != 0;
                m3_v = 1'b1;
                m3_oh = 3'(1 << a3);
            end else begin
                m3_y = 1'b0; m3_v = 1'b0; m3_oh = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_y", 32'(y), 32'(m_y));
            chk("model_valid", 32'(y_valid), 32'(m_v));
            chk("model_onehot", 32'(sel_onehot), 32'(m_oh));
            chk("model3_y", 32'(y3), 32'(m3_y));
            chk("model3_valid", 32'(y3_valid), 32'(m3_v));
            chk("model3_onehot", 32'(sel3_onehot), 32'(m3_oh));
        end
    end

    // Inputs change 1 time unit after the rising edge, so they are stable at
    // the next edge. Outputs are read once the task returns.
    task automatic cycle(input logic r, input logic e, input logic [1:0] av,
                         input logic [3:0] dv, input logic [1:0] a3v, input logic [2:0] d3v);
        rst = r; en = e; a = av; d = dv; a3 = a3v; d3 = d3v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] idx;
        rst = 1'b1; en = 1'b1; a = 2'd3; d = 4'hF; a3 = 2'd0; d3 = 3'd0;
        @(posedge clk);
        #1;
        checking = 1'b1;

        // Reset held for two edges with enable high.
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, 2'd3, 4'hF, 2'd2, 3'b111);
            chk("rst_y", 32'(y), 32'd0);
            chk("rst_valid", 32'(y_valid), 32'd0);
            chk("rst_onehot", 32'(sel_onehot), 32'd0);
        end

        // Exhaustive sweep of select and data.
        for (int unsigned ai = 0; ai < 4; ai++)
            for (int unsigned di = 0; di < 16; di++)
                cycle(1'b0, 1'b1, 2'(ai), 4'(di), 2'(ai), 3'(di));

        cycle(1'b0, 1'b1, 2'd2, 4'b0100, 2'd2, 3'b100);
        chk("lit_a2_d0100_y", 32'(y), 32'd1);
        chk("lit_a2_d0100_oh", 32'(sel_onehot), 32'b0100);
        cycle(1'b0, 1'b1, 2'd2, 4'b1011, 2'd2, 3'b011);
        chk("lit_a2_d1011_y", 32'(y), 32'd0);

        // Wider indices are truncated to two bits by the driver.
        idx = 5'd5;
        cycle(1'b0, 1'b1, idx[1:0], 4'b0010, idx[1:0], 3'b010);
        chk("wrap5_y", 32'(y), 32'd1);
        chk("wrap5_oh", 32'(sel_onehot), 32'b0010);
        idx = 5'd30;
        cycle(1'b0, 1'b1, idx[1:0], 4'b0100, idx[1:0], 3'b100);
        chk("wrap30_y", 32'(y), 32'd1);
        chk("wrap30_oh", 32'(sel_onehot), 32'b0100);

        // Enable low holds every output.
        cycle(1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 3'b001);
        chk("hold_cap_y", 32'(y), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 2'd3, 4'b0000, 2'd3, 3'b000);
            chk("hold_y", 32'(y), 32'd1);
            chk("hold_valid", 32'(y_valid), 32'd1);
            chk("hold_onehot", 32'(sel_onehot), 32'b0001);
        end

        // Reset wins over enable.
        cycle(1'b1, 1'b1, 2'd1, 4'b0010, 2'd1, 3'b010);
        chk("prio_y", 32'(y), 32'd0);
        chk("prio_valid", 32'(y_valid), 32'd0);
        cycle(1'b0, 1'b1, 2'd1, 4'b0010, 2'd1, 3'b010);
        chk("prio_release_y", 32'(y), 32'd1);
        chk("prio_release_valid", 32'(y_valid), 32'd1);

        // Out-of-range select on the 3-input instance.
        cycle(1'b0, 1'b1, 2'd3, 4'hF, 2'd3, 3'b111);
        chk("illegal_y", 32'(y3), 32'd0);
        chk("illegal_valid", 32'(y3_valid), 32'd0);
        chk("illegal_onehot", 32'(sel3_onehot), 32'd0);
        chk("legal4_a3_y", 32'(y), 32'd1);
        cycle(1'b0, 1'b1, 2'd2, 4'hF, 2'd2, 3'b111);
        chk("legal_after_y", 32'(y3), 32'd1);
        chk("legal_after_valid", 32'(y3_valid), 32'd1);
        chk("legal_after_onehot", 32'(sel3_onehot), 32'b100);

        // Randomised traffic with occasional reset and enable gaps.
        for (int k = 0; k < 400; k++)
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom), 4'($urandom), 2'($urandom), 3'($urandom));

        @(negedge clk);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
